jk_updown_counter: RTL and testbench
====================================

# jk_updown_counter

Synchronous up/down counter built from a row of JK storage cells with per-bit excitation logic generating each cell's J/K inputs. It sits directly above the JK flip-flop stage: this block computes J/K for every bit each cycle and consumes the q/qbar the cells produce. It supplies parallel load, count enable, terminal-count and wrap indication to downstream sequencing logic.

## Interface

- WIDTH, 4, number of counter bits / JK cells (≥2)
- clock  input  1  rising-edge clock, single domain
- clear  input  1  synchronous, active-low reset; sampled on rising clock edge
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe, overrides en
- din  input  WIDTH  parallel load value
- q  output  WIDTH  counter state (JK cell outputs)
- qbar  output  WIDTH  bitwise complement of q, always ~q
- tc  output  1  terminal count, combinational
- wrapped  output  1  registered one-cycle pulse after a wrap event

## Operation

- One clock; reset is synchronous and active-low: clock port `clock`, reset port `clear`.
- Per-cycle priority, evaluated at rising edge: clear low > load > en > hold.
- clear low: all cells forced to 0; wrapped cleared.
- load high: bit i driven J=din[i], K=~din[i]; q takes din next edge; wrapped <= 0.
- en high, up=1: bit i toggles (J=K=1) iff q[i-1:0] all ones; bit 0 always toggles.
- en high, up=0: bit i toggles iff q[i-1:0] all zeros; bit 0 always toggles.
- Otherwise: J=K=0 on all bits, q holds.
- Arithmetic modulo 2^WIDTH: all-ones +1 -> 0; 0 -1 -> all-ones.
- tc = clear & en & ~load & ((up & q==all-ones) | (~up & q==0)).
- wrapped <= 1 on an edge where tc=1 and the counter actually wrapped; else 0.
- din ignored unless load high; up ignored unless en high and load low.

## Timing

- Reset values: q=0, qbar=all ones, wrapped=0, tc=0 (tc forced low while clear low).
- Load/count latency: 1 cycle (q valid after the capturing edge).
- tc: zero-latency combinational from q, en, up, load, clear.
- wrapped: high exactly the cycle after the wrapping edge, for one cycle; continuous counting through consecutive wraps (WIDTH small) pulses each wrap.
- load and en together: load wins, no count, no wrap pulse.
- Direction change mid-count: takes effect on the next edge, no dead cycle.
- clear low mid-count or mid-load: state zero next edge regardless of load/en; counting resumes the first edge with clear high.

## Configuration

- JK_COUNTER_SATURATE_EN defined: at all-ones with up=1 or at 0 with up=0 while en, all cells get J=K=0 (hold); tc still asserts; wrapped never asserts.
- Not defined: modulo wrap as above; wrapped pulses on each wrap.

## Structure

- Shared package jk_pkg: excitation encoding constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11 ({J,K}), and a typedef for the 2-bit jk_ctrl_t.
- Sub-module jk_cell: one synchronous JK bit (ports j, k, clock, clear, q, qbar), instantiated WIDTH times via generate; excitation, tc and wrapped logic live in the top level.

## Test plan

- clear low 2 cycles with en=1, up=1 -> q=0, qbar=4'hF, tc=0, wrapped=0.
- load=1, din=4'hD, then en=1, up=1 for 3 cycles -> q=D, E, F, 0; tc=1 while q=F; wrapped=1 the cycle q=0 appears, 0 next cycle.
- q=0, en=1, up=0 -> tc=1, next q=4'hF, wrapped pulses; with JK_COUNTER_SATURATE_EN q stays 0, wrapped stays 0.
- load=1 and en=1 together at q=7, din=4'h2 -> q=2, no increment, wrapped=0.
- Counting at q=9, clear driven low one cycle with load=1, din=4'h5 -> q=0 next edge, then count resumes 1, 2 with clear high.
- en=0 for 5 cycles at q=4'h6, toggling up and din -> q holds 6, tc=0, wrapped=0.

Source files
------------

// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK up/down counter slice.
//   jk_ctrl_t : 2-bit excitation word, packed as {J,K}
//   JK_HOLD / JK_RESET / JK_SET / JK_TOGGLE : the four JK excitations
//   jk_load() : excitation that forces a cell to a given bit value
// -----------------------------------------------------------------------------
package jk_pkg;

    typedef logic [1:0] jk_ctrl_t;

    localparam jk_ctrl_t JK_HOLD   = 2'b00;
    localparam jk_ctrl_t JK_RESET  = 2'b01;
    localparam jk_ctrl_t JK_SET    = 2'b10;
    localparam jk_ctrl_t JK_TOGGLE = 2'b11;

    // Parallel load drives J=b, K=~b so the cell lands on b regardless of
    // its current state.
    function automatic jk_ctrl_t jk_load(input logic b);
        return b ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// One synchronous JK storage bit.
//   clock : rising-edge clock
//   clear : synchronous active-low clear, forces q to 0
//   j, k  : excitation inputs ({J,K} decoded with the jk_pkg encoding)
//   q     : stored bit
//   qbar  : complement of q
// -----------------------------------------------------------------------------
module jk_cell
    import jk_pkg::*;
(
    input  logic clock,
    input  logic clear,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    jk_ctrl_t jk;

    assign jk = {j, k};

    always_ff @(posedge clock) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            case (jk)
                JK_HOLD:  q <= q;
                JK_RESET: q <= 1'b0;
                JK_SET:   q <= 1'b1;
                default:  q <= ~q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_updown_counter.sv
// -----------------------------------------------------------------------------
// jk_updown_counter
// Synchronous up/down counter built from a row of jk_cell instances. This
// level computes the J/K excitation for every bit each cycle from the current
// cell outputs, and produces terminal-count and wrap indication.
//
// Parameters
//   WIDTH   : number of counter bits / JK cells (>= 2)
// Ports
//   clock   : rising-edge clock
//   clear   : synchronous active-low reset
//   en      : count enable
//   up      : direction, 1 = increment, 0 = decrement
//   load    : parallel load strobe, wins over en
//   din     : parallel load value
//   q       : counter state (cell outputs)
//   qbar    : complement of q (cell outputs)
//   tc      : terminal count, combinational
//   wrapped : one-cycle registered pulse the cycle after a wrap
//
// Build option
//   JK_COUNTER_SATURATE_EN : when defined, counting holds at the terminal
//   value instead of wrapping; tc still asserts, wrapped never does.
// -----------------------------------------------------------------------------
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrapped
);

    jk_ctrl_t [WIDTH-1:0] ctrl;
    logic                 at_term;
    logic                 sat_hold;
    logic                 wrap_evt;
    logic                 ones_run;
    logic                 zeros_run;

    // Terminal value for the current direction: all-ones going up, zero
    // going down.
    assign at_term = up ? (&q) : ~(|q);

    assign tc = clear & en & ~load & at_term;

`ifdef JK_COUNTER_SATURATE_EN
    // Freeze every cell at the terminal value rather than rolling over.
    assign sat_hold = at_term;
    assign wrap_evt = 1'b0;
`else
    assign sat_hold = 1'b0;
    // In modulo mode a count at the terminal value always rolls over.
    assign wrap_evt = tc;
`endif

    // Excitation. ones_run / zeros_run carry "all lower bits are 1 / 0" from
    // bit 0 upward; bit 0 sees both as 1, so it always toggles when counting.
    always_comb begin
        ctrl      = '0;
        ones_run  = 1'b1;
        zeros_run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            ctrl[i] = JK_HOLD;
            if (load) begin
                ctrl[i] = jk_load(din[i]);
            end else if (en && !sat_hold) begin
                if (up ? ones_run : zeros_run) begin
                    ctrl[i] = JK_TOGGLE;
                end
            end
            ones_run  = ones_run  &  q[i];
            zeros_run = zeros_run & ~q[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            jk_cell u_cell (
                .clock (clock),
                .clear (clear),
                .j     (ctrl[g][1]),
                .k     (ctrl[g][0]),
                .q     (q[g]),
                .qbar  (qbar[g])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!clear) begin
            wrapped <= 1'b0;
        end else begin
            wrapped <= wrap_evt;
        end
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;
`ifdef JK_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         clear, en, up, load;
    logic [W-1:0] din;
    logic [W-1:0] q, qbar;
    logic         tc, wrapped;

    int           n_cmp = 0;
    int           n_err = 0;

    // reference model state
    int           m_q  = 0;
    bit           m_wr = 1'b0;
    bit           exp_tc;
    logic         seen_tc;
    logic [W-1:0] exp_q;

    jk_updown_counter #(.WIDTH(W)) dut (
        .clock   (clock),
        .clear   (clear),
        .en      (en),
        .up      (up),
        .load    (load),
        .din     (din),
        .q       (q),
        .qbar    (qbar),
        .tc      (tc),
        .wrapped (wrapped)
    );

    always #5 clock = ~clock;

    // Apply one cycle of inputs, sample tc mid-cycle, advance the model
    // across the rising edge, and leave time 1 unit past that edge.
    task automatic drive(input bit cl, input bit ld, input bit e, input bit u,
                         input logic [W-1:0] d);
        int nxt;
        bit over;
        clear = cl; load = ld; en = e; up = u; din = d;
        #1;
        exp_tc  = cl && e && !ld && ((u && m_q == MAX) || (!u && m_q == 0));
        seen_tc = tc;
        @(posedge clock);
        if (!cl) begin
            m_q = 0; m_wr = 0;
        end else if (ld) begin
            m_q = int'(d); m_wr = 0;
        end else if (e) begin
            nxt  = u ? m_q + 1 : m_q - 1;
            over = (nxt < 0) || (nxt > MAX);
            if (over && SAT) begin
                m_wr = 0;
            end else begin
                m_q  = (nxt + (MAX + 1)) % (MAX + 1);
                m_wr = over;
            end
        end else begin
            m_wr = 0;
        end
        exp_q = m_q[W-1:0];
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 1, 4'h0);
        drive(0, 0, 1, 1, 4'h3);
        n_cmp++; if (q !== 4'h0) begin n_err++; $display("FAIL reset_q got=%h want=0", q); end
        n_cmp++; if (qbar !== 4'hF) begin n_err++; $display("FAIL reset_qbar got=%h want=F", qbar); end
        n_cmp++; if (seen_tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%b want=0", seen_tc); end
        n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL reset_wrapped got=%b want=0", wrapped); end
    endtask

    task automatic test_load_count_up();
        logic [W-1:0] seq [3];
        seq[0] = 4'hE; seq[1] = 4'hF; seq[2] = 4'h0;
        drive(1, 1, 0, 0, 4'hD);
        n_cmp++; if (q !== 4'hD) begin n_err++; $display("FAIL load_q got=%h want=D", q); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 4'h0);
            n_cmp++; if (q !== seq[i]) begin n_err++; $display("FAIL up_q[%0d] got=%h want=%h", i, q, seq[i]); end
            n_cmp++; if (seen_tc !== exp_tc) begin n_err++; $display("FAIL up_tc[%0d] got=%b want=%b", i, seen_tc, exp_tc); end
            n_cmp++; if (wrapped !== m_wr) begin n_err++; $display("FAIL up_wrapped[%0d] got=%b want=%b", i, wrapped, m_wr); end
        end
        drive(1, 0, 0, 1, 4'h0);
        n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL wrap_pulse_len got=%b want=0", wrapped); end
    endtask

    task automatic test_down_wrap();
        drive(1, 1, 0, 0, 4'h0);
        drive(1, 0, 1, 0, 4'h0);
        n_cmp++; if (seen_tc !== 1'b1) begin n_err++; $display("FAIL down_tc got=%b want=1", seen_tc); end
        n_cmp++; if (q !== exp_q) begin n_err++; $display("FAIL down_q got=%h want=%h", q, exp_q); end
        n_cmp++; if (wrapped !== m_wr) begin n_err++; $display("FAIL down_wrapped got=%b want=%b", wrapped, m_wr); end
    endtask

    task automatic test_load_over_en();
        drive(1, 1, 0, 0, 4'h7);
        drive(1, 1, 1, 1, 4'h2);
        n_cmp++; if (q !== 4'h2) begin n_err++; $display("FAIL load_en_q got=%h want=2", q); end
        n_cmp++; if (seen_tc !== 1'b0) begin n_err++; $display("FAIL load_en_tc got=%b want=0", seen_tc); end
        n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL load_en_wrapped got=%b want=0", wrapped); end
    endtask

    task automatic test_clear_mid();
        drive(1, 1, 0, 0, 4'h9);
        drive(0, 1, 1, 1, 4'h5);
        n_cmp++; if (q !== 4'h0) begin n_err++; $display("FAIL clear_mid_q got=%h want=0", q); end
        drive(1, 0, 1, 1, 4'h5);
        n_cmp++; if (q !== 4'h1) begin n_err++; $display("FAIL resume1_q got=%h want=1", q); end
        drive(1, 0, 1, 1, 4'h5);
        n_cmp++; if (q !== 4'h2) begin n_err++; $display("FAIL resume2_q got=%h want=2", q); end
    endtask

    task automatic test_hold();
        drive(1, 1, 0, 0, 4'h6);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 1'($urandom), 4'($urandom));
            n_cmp++; if (q !== 4'h6) begin n_err++; $display("FAIL hold_q[%0d] got=%h want=6", i, q); end
            n_cmp++; if (seen_tc !== 1'b0) begin n_err++; $display("FAIL hold_tc[%0d] got=%b want=0", i, seen_tc); end
            n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL hold_wrapped[%0d] got=%b want=0", i, wrapped); end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 0, 4'hE);
        for (int i = 0; i < 36; i++) begin
            drive(1, 0, 1, 1, 4'h0);
            n_cmp++; if (q !== exp_q) begin n_err++; $display("FAIL b2b_q[%0d] got=%h want=%h", i, q, exp_q); end
            n_cmp++; if (wrapped !== m_wr) begin n_err++; $display("FAIL b2b_wrapped[%0d] got=%b want=%b", i, wrapped, m_wr); end
            n_cmp++; if (seen_tc !== exp_tc) begin n_err++; $display("FAIL b2b_tc[%0d] got=%b want=%b", i, seen_tc, exp_tc); end
        end
    endtask

    task automatic test_random();
        bit cl, ld, e, u;
        for (int i = 0; i < 400; i++) begin
            cl = ($urandom_range(0, 19) != 0);
            ld = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom);
            drive(cl, ld, e, u, 4'($urandom));
            n_cmp++; if (q !== exp_q) begin n_err++; $display("FAIL rnd_q[%0d] got=%h want=%h", i, q, exp_q); end
            n_cmp++; if (qbar !== ~exp_q) begin n_err++; $display("FAIL rnd_qbar[%0d] got=%h want=%h", i, qbar, ~exp_q); end
            n_cmp++; if (seen_tc !== exp_tc) begin n_err++; $display("FAIL rnd_tc[%0d] got=%b want=%b", i, seen_tc, exp_tc); end
            n_cmp++; if (wrapped !== m_wr) begin n_err++; $display("FAIL rnd_wrapped[%0d] got=%b want=%b", i, wrapped, m_wr); end
        end
    endtask

    initial begin
        clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; din = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_load_count_up();
        test_down_wrap();
        test_load_over_en();
        test_clear_mid();
        test_hold();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
